vc_link_buffer: RTL and testbench

VC_LINK_BUFFER -- requirements
Module: vc_link_buffer

---
 rtl/noc_pkg.sv | 11 +
 rtl/vc_fifo.sv | 56 +++++
 rtl/vc_link_buffer.sv | 115 +++++++++++
 tb/tb_vc_link_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared defaults and the flit type for the NoC link-buffer slice.
package noc_pkg;

  localparam int NOC_DATA_W      = 16;
  localparam int NOC_NUM_VC      = 4;
  localparam int NOC_DEPTH       = 4;
  localparam int NOC_CREDIT_INIT = 4;

  typedef logic [NOC_DATA_W-1:0] flit_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO; a pop in the same cycle frees a slot
// so a push into a full FIFO still succeeds.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W = NOC_DATA_W,
  parameter int DEPTH  = NOC_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/vc_link_buffer.sv
// Per-VC input buffering with credit-based flow control and a round-robin
// output arbiter that emits at most one registered flit per cycle.
module vc_link_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W      = NOC_DATA_W,
  parameter int NUM_VC      = NOC_NUM_VC,
  parameter int DEPTH       = NOC_DEPTH,
  parameter int CREDIT_INIT = NOC_CREDIT_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_VC-1:0] valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [NUM_VC-1:0] credit_o,
  output logic [NUM_VC-1:0] valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [NUM_VC-1:0] credit_i,
  output logic              err_o
);

  localparam int VW = $clog2(NUM_VC);
  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_INIT);
  localparam logic [VW-1:0] LAST_VC    = VW'(NUM_VC - 1);

  // Handshake: upstream pushes are fire-and-forget (valid_i only, the sender
  // owns credits); downstream sees valid_o with no ready and returns
  // credit_i one pulse per freed slot.

  logic              multi_hot;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] fifo_full;
  logic [NUM_VC-1:0] fifo_empty;
  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] gnt;
  logic [NUM_VC-1:0] drop;
  logic [NUM_VC-1:0] credit_sat;
  logic [DATA_W-1:0] heads [NUM_VC];
  logic [CW-1:0]     credit_q [NUM_VC];
  logic [VW-1:0]     last_grant;
  logic [VW-1:0]     gnt_idx;
  logic [VW-1:0]     cand;
  logic              any_gnt;

  assign multi_hot = |(valid_i & (valid_i - NUM_VC'(1)));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v]       = valid_i[v] & ~multi_hot;
    assign eligible[v]   = ~fifo_empty[v] & (credit_q[v] != '0);
    assign drop[v]       = push[v] & fifo_full[v] & ~gnt[v];
    assign credit_sat[v] = credit_i[v] & ~gnt[v] & (credit_q[v] == CREDIT_MAX);

    vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push[v]),
      .pop     (gnt[v]),
      .data_in (data_i),
      .full    (fifo_full[v]),
      .empty   (fifo_empty[v]),
      .head    (heads[v])
    );

    // A grant and a returned credit on the same edge cancel out.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        credit_q[v] <= CREDIT_MAX;
      end else if (gnt[v] && !credit_i[v]) begin
        credit_q[v] <= credit_q[v] - CW'(1);
      end else if (credit_i[v] && !gnt[v] && (credit_q[v] != CREDIT_MAX)) begin
        credit_q[v] <= credit_q[v] + CW'(1);
      end
    end
  end

  // Search starts one past the last winner so every eligible VC is served
  // within NUM_VC grants.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    any_gnt = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      cand = VW'((int'(last_grant) + i) % NUM_VC);
      if (!any_gnt && eligible[cand]) begin
        any_gnt = 1'b1;
        gnt_idx = cand;
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o    <= '0;
      credit_o   <= '0;
      data_o     <= '0;
      err_o      <= 1'b0;
      last_grant <= LAST_VC;
    end else begin
      valid_o  <= gnt;
      credit_o <= gnt;
      if (any_gnt) begin
        data_o     <= heads[gnt_idx];
        last_grant <= gnt_idx;
      end
      if (multi_hot || (|drop) || (|credit_sat)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_link_buffer.sv
// Directed bench for vc_link_buffer with an expected-flit queue checked at
// every emitted flit.
module tb_vc_link_buffer;

  localparam int DW = 16;
  localparam int NV = 4;

  logic          clk;
  logic          reset;
  logic [NV-1:0] valid_i;
  logic [DW-1:0] data_i;
  logic [NV-1:0] credit_o;
  logic [NV-1:0] valid_o;
  logic [DW-1:0] data_o;
  logic [NV-1:0] credit_i;
  logic          err_o;

  int vectors     = 0;
  int miscompares = 0;
  int emitted     = 0;
  int e0;
  logic [NV+DW-1:0] exp_q [$];
  logic [NV+DW-1:0] exp_word;

  vc_link_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .credit_o (credit_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .credit_i (credit_i),
    .err_o    (err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int vc, input logic [DW-1:0] d);
    valid_i = 4'b0001 << vc;
    data_i  = d;
    tick();
    valid_i = '0;
  endtask

  task automatic expect_flit(input int vc, input logic [DW-1:0] d);
    logic [NV-1:0] oh;
    oh = 4'b0001 << vc;
    exp_q.push_back({oh, d});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_o !== '0) begin
      emitted++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_flit observed=%0h expected=none", {valid_o, data_o});
      end
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        vectors++;
        assert ({valid_o, data_o} === exp_word) else begin
          miscompares++;
          $error("FAIL flit_order observed=%0h expected=%0h", {valid_o, data_o}, exp_word);
        end
      end
      vectors++;
      assert (credit_o === valid_o) else begin
        miscompares++;
        $error("FAIL credit_pulse observed=%0h expected=%0h", credit_o, valid_o);
      end
    end
  end

  initial begin
    reset = 1'b1; valid_i = '0; data_i = '0; credit_i = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_credit_o", 32'(credit_o), 32'h0);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    for (int v = 0; v < NV; v++) check($sformatf("rst_credit%0d", v), 32'(dut.credit_q[v]), 32'd4);
    #10 reset = 1'b1;
    tick();

    // single flit, two-clock latency
    expect_flit(0, 16'hA5A5);
    send(0, 16'hA5A5);
    tick();
    check("single_valid", 32'(valid_o), 32'h1);
    check("single_data", 32'(data_o), 32'hA5A5);
    check("single_credit_o", 32'(credit_o), 32'h1);
    check("single_credit0", 32'(dut.credit_q[0]), 32'd3);
    credit_i = 4'b0001; tick(); credit_i = '0;
    check("single_restore", 32'(dut.credit_q[0]), 32'd4);

    // credit exhaustion on VC1
    e0 = emitted;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expect_flit(1, 16'h1100 + 16'(k));
      send(1, 16'h1100 + 16'(k));
    end
    repeat (4) tick();
    check("exhaust_count", 32'(emitted - e0), 32'd4);
    check("exhaust_credit1", 32'(dut.credit_q[1]), 32'd0);
    expect_flit(1, 16'h1104);
    credit_i = 4'b0010; tick(); credit_i = '0;
    tick();
    check("exhaust_fifth_valid", 32'(valid_o), 32'h2);
    check("exhaust_fifth_data", 32'(data_o), 32'h1104);
    expect_flit(1, 16'h1105);
    credit_i = 4'b0010; repeat (5) tick(); credit_i = '0;
    tick();
    check("exhaust_restore", 32'(dut.credit_q[1]), 32'd4);
    check("exhaust_err", 32'(err_o), 32'h0);

    // grant and credit return on VC3 at the same edge
    expect_flit(3, 16'h3333);
    send(3, 16'h3333);
    credit_i = 4'b1000; tick(); credit_i = '0;
    check("simul_valid", 32'(valid_o), 32'h8);
    check("simul_credit3", 32'(dut.credit_q[3]), 32'd4);

    // drain every VC's credit, then preload 3 flits each for fairness
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < 4; k++) begin
        expect_flit(v, 16'hD000 + 16'(v * 16 + k));
        send(v, 16'hD000 + 16'(v * 16 + k));
      end
      repeat (3) tick();
      check($sformatf("drain_credit%0d", v), 32'(dut.credit_q[v]), 32'd0);
    end
    for (int r = 0; r < 3; r++)
      for (int v = 0; v < NV; v++) send(v, 16'hF000 + 16'(r * 16 + v));
    check("fair_held", 32'(valid_o), 32'h0);
    for (int r = 0; r < 3; r++)
      for (int v = 0; v < NV; v++) expect_flit(v, 16'hF000 + 16'(r * 16 + v));
    e0 = emitted;
    credit_i = 4'hF; repeat (4) tick(); credit_i = '0;
    repeat (14) tick();
    check("fair_count", 32'(emitted - e0), 32'd12);
    for (int v = 0; v < NV; v++) check($sformatf("fair_credit%0d", v), 32'(dut.credit_q[v]), 32'd1);
    credit_i = 4'hF; repeat (3) tick(); credit_i = '0;
    tick();
    for (int v = 0; v < NV; v++) check($sformatf("fair_restore%0d", v), 32'(dut.credit_q[v]), 32'd4);

    // full FIFO push and pop on the same edge (VC2)
    for (int k = 0; k < 4; k++) begin
      expect_flit(2, 16'h2200 + 16'(k));
      send(2, 16'h2200 + 16'(k));
    end
    repeat (3) tick();
    for (int k = 0; k < 4; k++) send(2, 16'h2300 + 16'(k));
    check("pp_full_err", 32'(err_o), 32'h0);
    credit_i = 4'b0100; tick(); credit_i = '0;
    expect_flit(2, 16'h2300);
    valid_i = 4'b0100; data_i = 16'h2304;
    tick();
    valid_i = '0;
    check("pp_err", 32'(err_o), 32'h0);
    check("pp_valid", 32'(valid_o), 32'h4);
    check("pp_data", 32'(data_o), 32'h2300);
    for (int k = 1; k <= 4; k++) expect_flit(2, 16'h2300 + 16'(k));
    credit_i = 4'b0100; repeat (4) tick(); credit_i = '0;
    repeat (2) tick();
    check("pp_drained", 32'(exp_q.size()), 32'd0);

    // overflow: fifth write dropped, first four kept in order
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("ovf_err_before", 32'(err_o), 32'h0);
      send(2, 16'h2A00 + 16'(k));
    end
    check("ovf_err", 32'(err_o), 32'h1);
    for (int k = 0; k < 4; k++) expect_flit(2, 16'h2A00 + 16'(k));
    credit_i = 4'b0100; repeat (4) tick(); credit_i = '0;
    repeat (4) tick();
    check("ovf_order", 32'(exp_q.size()), 32'd0);

    // reset mid-operation with 3 flits still buffered
    for (int k = 0; k < 4; k++) send(2, 16'h2B00 + 16'(k));
    credit_i = 4'b0100; tick(); credit_i = '0;
    tick();
    check("mid_valid", 32'(valid_o), 32'h4);
    check("mid_data", 32'(data_o), 32'h2B00);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_data", 32'(data_o), 32'h0);
    check("mid_rst_err", 32'(err_o), 32'h0);
    valid_i = 4'b0001; data_i = 16'hBAD0;
    repeat (2) tick();
    valid_i = '0;
    reset = 1'b1;
    for (int v = 0; v < NV; v++) check($sformatf("post_rst_credit%0d", v), 32'(dut.credit_q[v]), 32'd4);
    repeat (6) tick();
    check("post_rst_idle", 32'(valid_o), 32'h0);
    expect_flit(0, 16'h5A5A);
    send(0, 16'h5A5A);
    tick();
    check("post_rst_valid", 32'(valid_o), 32'h1);
    check("post_rst_data", 32'(data_o), 32'h5A5A);

    // more than one valid bit: no write, sticky error
    valid_i = 4'b0011; data_i = 16'h7777;
    tick();
    valid_i = '0;
    repeat (3) tick();
    check("multi_err", 32'(err_o), 32'h1);
    check("multi_nowrite", 32'(valid_o), 32'h0);
    repeat (2) tick();
    check("multi_sticky", 32'(err_o), 32'h1);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
